// File: rtl/mb_frame_writer_if.sv
// ---------------------------------------------------------------------------
// mb_frame_writer_pkg / ddr_if
//
// Purpose : Shared types and the DDR host-port bundle for the macroblock
//           frame writer.
//
// planar_yuv_s : byte base addresses of the Y, U and V planes of one frame
//                buffer (all 8-byte aligned).
//
// ddr_if modports
//   to_host   : client side (drives the request, samples busy)
//   from_host : DDR controller side (samples the request, drives busy)
//   addr[28:0]      word address
//   write / read    single-beat request strobes
//   acquire         client holds the port across a sequence of beats
//   burstcnt[7:0]   beats per request
//   byteenable[7:0] byte lane enables
//   wdata[63:0]     write data
//   busy            controller cannot accept the presented request
// ---------------------------------------------------------------------------
package mb_frame_writer_pkg;

    typedef struct packed {
        logic [28:0] y_adr;
        logic [28:0] u_adr;
        logic [28:0] v_adr;
    } planar_yuv_s;

endpackage

interface ddr_if;
    logic [28:0] addr;
    logic        write;
    logic        read;
    logic        acquire;
    logic [7:0]  burstcnt;
    logic [7:0]  byteenable;
    logic [63:0] wdata;
    logic        busy;

    modport to_host (
        output addr, write, read, acquire, burstcnt, byteenable, wdata,
        input  busy
    );

    modport from_host (
        input  addr, write, read, acquire, burstcnt, byteenable, wdata,
        output busy
    );
endinterface

// File: rtl/mb_frame_writer.sv
// ---------------------------------------------------------------------------
// mb_frame_writer
//
// Purpose : Collects the eight 64-bit rows of a decoded 8x8 block (Y, U or V)
//           and writes each row as one single-beat DDR word at its raster
//           address in a planar YUV frame buffer.
//
// Ports
//   clkddr       DDR clock, all logic lives here
//   reset        synchronous, active-high
//   ddrif        DDR host port (ddr_if.to_host)
//   frame        plane base byte addresses, latched on pic_start
//   frame_width  luma width in pixels, latched on pic_start
//   pic_start    latch pulse for frame / frame_width
//   in_valid / in_ready / in_data   row word stream (byte 0 = leftmost pixel)
//   in_first     row 0 of a block, qualifies mb_x / mb_y / block_idx
//   mb_x, mb_y   macroblock column / row
//   block_idx    0-3 luma (raster in MB), 4 = U, 5 = V, 6/7 discarded
//   block_done   one-cycle pulse once the block is finished
//   idle         high while waiting for a new block
// ---------------------------------------------------------------------------
module mb_frame_writer
    import mb_frame_writer_pkg::*;
#(
    parameter logic [3:0] DDR_CORE_BASE = 4'b0011,
    parameter int         MAX_WIDTH     = 384
) (
    input  logic         clkddr,
    input  logic         reset,
    ddr_if.to_host       ddrif,
    input  planar_yuv_s  frame,
    input  logic [8:0]   frame_width,
    input  logic         pic_start,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [63:0]  in_data,
    input  logic         in_first,
    input  logic [4:0]   mb_x,
    input  logic [4:0]   mb_y,
    input  logic [2:0]   block_idx,
    output logic         block_done,
    output logic         idle
);

    localparam int STRIDE_W = $clog2(MAX_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, COLLECT, WRITE, ISSUED} state_e;

    state_e               state_q, state_d;
    logic [63:0]          rowBuf_q [8];
    logic [2:0]           rowCnt_q;
    logic [2:0]           rIdx_q;
    logic [4:0]           mbX_q, mbY_q;
    logic [2:0]           blkIdx_q;
    logic [28:0]          blkBase_q;
    logic [STRIDE_W-1:0]  blkStride_q;
    logic [28:0]          rowAdr_q;
    planar_yuv_s          frameLat_q;
    logic [8:0]           widthLat_q;
    logic                 write_q;
    logic [28:0]          addr_q;
    logic [63:0]          wdata_q;
    logic                 blockDone_q;

    logic                 accept;
    logic                 lastRow;
    logic                 illegalBlk;
    planar_yuv_s          curFrame;
    logic [8:0]           curWidth;
    logic [28:0]          selBase;
    logic [STRIDE_W-1:0]  selStride;
    logic [28:0]          pxW, pyW, strideW, startAdr;

    assign accept     = in_valid && in_ready;
    assign lastRow    = (rowCnt_q == 3'd7);
    assign illegalBlk = (blkIdx_q[2:1] == 2'b11);

    // A block samples its plane base and stride on its first row. When
    // pic_start arrives in the same cycle, the incoming values are used
    // directly so the block does not pick up the previous picture.
    always_comb begin
        curFrame  = pic_start ? frame : frameLat_q;
        curWidth  = pic_start ? frame_width : widthLat_q;
        selBase   = curFrame.y_adr;
        selStride = STRIDE_W'(curWidth);
        if (block_idx == 3'd4) begin
            selBase   = curFrame.u_adr;
            selStride = STRIDE_W'(curWidth >> 1);
        end else if (block_idx == 3'd5) begin
            selBase   = curFrame.v_adr;
            selStride = STRIDE_W'(curWidth >> 1);
        end
    end

    // Byte address of row 0. Luma blocks sit on a 16-pixel MB grid with an
    // 8-pixel offset per block_idx bit; chroma planes are half resolution.
    always_comb begin
        strideW = 29'(blkStride_q);
        if (!blkIdx_q[2]) begin
            pxW = {20'd0, mbX_q, 4'd0} + {25'd0, blkIdx_q[0], 3'd0};
            pyW = {20'd0, mbY_q, 4'd0} + {25'd0, blkIdx_q[1], 3'd0};
        end else begin
            pxW = {21'd0, mbX_q, 3'd0};
            pyW = {21'd0, mbY_q, 3'd0};
        end
        startAdr = blkBase_q + pyW * strideW + pxW;
    end

    // State register.
    always_ff @(posedge clkddr) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. A new in_first always restarts collection, even on
    // what would have been the eighth row.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept && in_first) begin
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (accept && !in_first && lastRow) begin
                    state_d = illegalBlk ? IDLE : WRITE;
                end
            end
            WRITE: begin
                state_d = ISSUED;
            end
            ISSUED: begin
                if (!ddrif.busy) begin
                    state_d = (rIdx_q == 3'd7) ? IDLE : WRITE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode. in_ready is masked during reset so nothing is
    // accepted while the state is being forced.
    always_comb begin
        in_ready      = 1'b0;
        ddrif.acquire = 1'b0;
        idle          = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = !reset;
                idle     = 1'b1;
            end
            COLLECT: begin
                in_ready = !reset;
            end
            WRITE, ISSUED: begin
                ddrif.acquire = 1'b1;
            end
            default: ;
        endcase
    end

    assign ddrif.write      = write_q;
    assign ddrif.read       = 1'b0;
    assign ddrif.burstcnt   = 8'd1;
    assign ddrif.byteenable = 8'hff;
    assign ddrif.addr       = addr_q;
    assign ddrif.wdata      = wdata_q;
    assign block_done       = blockDone_q;

    // Row buffer; contents are don't-care until a block has been collected.
    always_ff @(posedge clkddr) begin
        if (accept && (in_first || state_q == COLLECT)) begin
            rowBuf_q[in_first ? 3'd0 : rowCnt_q] <= in_data;
        end
    end

    // Datapath: picture latch, block capture, row address walk and the
    // registered DDR request. The address advances by one stride per row,
    // so only row 0 needs the multiplier.
    always_ff @(posedge clkddr) begin
        if (reset) begin
            frameLat_q  <= '0;
            widthLat_q  <= '0;
            rowCnt_q    <= '0;
            rIdx_q      <= '0;
            mbX_q       <= '0;
            mbY_q       <= '0;
            blkIdx_q    <= '0;
            blkBase_q   <= '0;
            blkStride_q <= '0;
            rowAdr_q    <= '0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            blockDone_q <= 1'b0;
        end else begin
            blockDone_q <= 1'b0;
            if (pic_start) begin
                frameLat_q <= frame;
                widthLat_q <= frame_width;
            end
            if (accept) begin
                if (in_first) begin
                    mbX_q       <= mb_x;
                    mbY_q       <= mb_y;
                    blkIdx_q    <= block_idx;
                    blkBase_q   <= selBase;
                    blkStride_q <= selStride;
                    rowCnt_q    <= 3'd1;
                end else if (state_q == COLLECT) begin
                    rowCnt_q <= rowCnt_q + 3'd1;
                    if (lastRow) begin
                        rowAdr_q <= startAdr;
                        rIdx_q   <= 3'd0;
                        if (illegalBlk) begin
                            blockDone_q <= 1'b1;
                        end
                    end
                end
            end
            case (state_q)
                WRITE: begin
                    write_q <= 1'b1;
                    addr_q  <= {DDR_CORE_BASE, rowAdr_q[27:3]};
                    wdata_q <= rowBuf_q[rIdx_q];
                end
                ISSUED: begin
                    if (!ddrif.busy) begin
                        write_q <= 1'b0;
                        if (rIdx_q == 3'd7) begin
                            blockDone_q <= 1'b1;
                        end else begin
                            rIdx_q   <= rIdx_q + 3'd1;
                            rowAdr_q <= rowAdr_q + 29'(blkStride_q);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mb_frame_writer.md
Name: mb_frame_writer

Overview:
- Writes decoded 8x8 MPEG blocks (4 Y, 1 U, 1 V per macroblock) from the FMV decoder into a planar YUV frame buffer in DDR.
- It is the producer of the frame buffers that the FMV frame player later reads for display.
- Each 8-pixel block row is one 64-bit DDR word, written with a single-beat burst at the computed raster address.
- The block runs entirely in the clkddr domain.

Parameters:
- DDR_CORE_BASE, 4'b0011, upper 4 bits of every DDR word address.
- MAX_WIDTH, 384, largest supported frame_width (pixels); used for arithmetic sizing only.

Ports:
- clkddr  input  1  DDR clock; all logic is in this domain.
- reset  input  1  synchronous, active-high.
- ddrif  ddr_if.to_host  -  DDR port. Drives addr[28:0], write, read(=0), acquire, burstcnt[7:0], byteenable(=8'hff), wdata[63:0]; samples busy.
- frame  input  planar_yuv_s  target buffer base byte addresses (y_adr, u_adr, v_adr); all 8-byte aligned.
- frame_width  input  9  luma width in pixels, multiple of 16.
- pic_start  input  1  pulse; latches frame and frame_width for subsequent blocks.
- in_valid  input  1  row word valid.
- in_ready  output  1  row word accepted when in_valid && in_ready.
- in_data  input  64  8 pixels; byte 0 (bits 7:0) = leftmost pixel.
- in_first  input  1  marks row 0 of a block; qualifies mb_x/mb_y/block_idx.
- mb_x  input  5  macroblock column.
- mb_y  input  5  macroblock row.
- block_idx  input  3  0-3 = Y (raster order within the MB), 4 = U, 5 = V; 6 and 7 are illegal.
- block_done  output  1  one-cycle pulse after the 8th row write is accepted by DDR.
- idle  output  1  high in IDLE with no pending write.

Behaviour:
- Reset values: in_ready=0, write=0, read=0, acquire=0, burstcnt=1, byteenable=8'hff, block_done=0, idle=1, state=IDLE. Latched frame and width are cleared to 0.
- pic_start: frame and frame_width are latched on the next edge. A block already in progress finishes using its own sampled addresses. pic_start coincident with in_first: the block uses the newly latched values.
- States are IDLE, COLLECT, WRITE, ISSUED.
- IDLE:
  - in_ready=1.
  - An accepted word with in_first: store the row in buf[0], sample mb_x/mb_y/block_idx, row_cnt=1, go to COLLECT.
  - Accepted words without in_first are dropped.
- COLLECT:
  - in_ready=1; each accept writes buf[row_cnt] and increments row_cnt.
  - An accept with in_first restarts the block: buf[0], new coords, row_cnt=1.
  - When the 8th row is accepted, go to WRITE and drop in_ready on the next cycle.
- Address computation (registered once per block; 1 cycle latency inside WRITE entry):
  - Y blocks: px = mb_x*16 + 8*block_idx[0]; py = mb_y*16 + 8*block_idx[1]; stride = width; base = y_adr.
  - U/V blocks: px = mb_x*8; py = mb_y*8; stride = width/2; base = u_adr or v_adr.
  - row_adr[r] = base + py*stride + px + r*stride, computed in 29 bits; overflow wraps at 29 bits and is not checked.
  - DDR word address = {DDR_CORE_BASE, row_adr[27:3]}.
- WRITE:
  - acquire=1; present addr and wdata=buf[r] with write=1, burstcnt=1; go to ISSUED.
- ISSUED:
  - Hold write, addr and wdata stable while busy=1.
  - On the first cycle with busy=0 while write=1, that write is accepted and write drops on the next edge.
  - If r<7: r++ and return to WRITE. The next write is presented 1 cycle later, so there is at least one idle cycle between beats.
  - If r==7: acquire=0, block_done=1 for one cycle, go to IDLE.
- Throughput: at best, 8 input cycles plus 16 DDR cycles per block. There is no overlap of collection and writing.
- Illegal block_idx 6 or 7: the block is collected and discarded without DDR traffic. block_done is still pulsed.
- Reset mid-write: write and acquire are 0 on the next edge, and the partial block is lost.
- in_valid while in_ready=0: ignored; the producer holds the word.

Test Plan:
- Latch y_adr=0x100000, width=352; send block mb(0,0) idx0 -> 8 writes at addr {0011,0x20000 + r*0x2C}, i.e. row1 = 0x2002C; wdata equals each row in order; block_done pulses once.
- Send mb(1,2) idx3 -> first write addr low 25 bits = 0x206E3 (byte 0x103718); subsequent rows step +0x2C.
- With u_adr=0x200000, send mb(2,1) idx4 -> first addr low 25 bits = 0x400B2; rows step +0x16 (176/8); no write touches the Y plane.
- Hold busy=1 for 5 cycles on row 3 -> write, addr and wdata are stable for all 5 cycles; exactly 8 accepted writes total; acquire stays high until block_done.
- Assert in_first again after 4 rows -> the first partial block is discarded; only the second block's 8 rows are written, at the second block's coordinates.
- Assert reset during row 5 of WRITE -> write=0, acquire=0, idle=1 next cycle; a following block writes correctly starting at row 0.
